// File: rtl/word_byte_pkg.sv
// Shared types and helpers for the 16-bit word to 8-bit byte unpacker.
package word_byte_pkg;

  localparam int WORD_W = 16;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    EMPTY  = 2'b00,
    FIRST  = 2'b01,
    SECOND = 2'b10
  } state_t;

  // idx 0 is the first byte emitted; swap=1 sends the upper byte first.
  function automatic logic [BYTE_W-1:0] pick_byte(input logic [WORD_W-1:0] word,
                                                  input logic              swap,
                                                  input logic              idx);
    return (swap ^ idx) ? word[WORD_W-1:BYTE_W] : word[BYTE_W-1:0];
  endfunction

endpackage

// File: rtl/word_byte_sel.sv
// Combinational 16-to-8 byte selector keyed by emission order and FSM state.
module word_byte_sel
  import word_byte_pkg::*;
#(
  parameter bit SWAP = 1'b1
) (
  input  logic [WORD_W-1:0] word,
  input  state_t            state,
  output logic [BYTE_W-1:0] sel_byte
);

  // Forcing zero when idle keeps out_data clean regardless of the hold contents.
  always_comb begin
    sel_byte = '0;
    case (state)
      FIRST:   sel_byte = pick_byte(word, SWAP, 1'b0);
      SECOND:  sel_byte = pick_byte(word, SWAP, 1'b1);
      default: sel_byte = '0;
    endcase
  end

endmodule

// File: rtl/word_byte_unpacker.sv
// Unpacks 16-bit words into two bytes with valid/ready on both sides.
// Define WORD_BYTE_UNPACKER_LAST_EN to add the out_last end-of-word marker.
module word_byte_unpacker
  import word_byte_pkg::*;
#(
  parameter bit SWAP = 1'b1
) (
  input  logic              CLK,
  input  logic              ARST_N,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
`ifdef WORD_BYTE_UNPACKER_LAST_EN
  ,
  output logic              out_last
`endif
);

  state_t            state;
  logic [WORD_W-1:0] hold;
  logic              active;
  logic              word_xfer;
  logic              byte_xfer;

  // SECOND passes out_ready through so a new word can land as the last byte leaves.
  assign in_ready  = (state == EMPTY) || ((state == SECOND) && out_ready);
  assign word_xfer = in_valid && in_ready;
  assign byte_xfer = active && out_ready;

  assign out_valid = active;
  assign busy      = active;

`ifdef WORD_BYTE_UNPACKER_LAST_EN
  assign out_last = (state == SECOND);
`endif

  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state  <= EMPTY;
      hold   <= '0;
      active <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (word_xfer) begin
            hold   <= in_data;
            state  <= FIRST;
            active <= 1'b1;
          end
        end
        FIRST: begin
          if (byte_xfer) state <= SECOND;
        end
        SECOND: begin
          if (byte_xfer) begin
            if (word_xfer) begin
              hold  <= in_data;
              state <= FIRST;
            end else begin
              state  <= EMPTY;
              active <= 1'b0;
            end
          end
        end
        default: begin
          state  <= EMPTY;
          active <= 1'b0;
        end
      endcase
    end
  end

  word_byte_sel #(
    .SWAP(SWAP)
  ) u_sel (
    .word    (hold),
    .state   (state),
    .sel_byte(out_data)
  );

endmodule

// File: tb/tb_word_byte_unpacker.sv
// Directed table-driven bench for word_byte_unpacker, both byte orders side by side.
module tb_word_byte_unpacker;

  logic        CLK = 1'b0;
  logic        ARST_N = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;

  logic        ir1, ov1, busy1, ir0, ov0, busy0;
  logic [7:0]  d1, d0;
`ifdef WORD_BYTE_UNPACKER_LAST_EN
  logic        last1, last0;
`endif

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  word_byte_unpacker #(.SWAP(1'b1)) u_swap1 (
    .CLK(CLK), .ARST_N(ARST_N), .in_data(in_data), .in_valid(in_valid), .in_ready(ir1),
    .out_data(d1), .out_valid(ov1), .out_ready(out_ready), .busy(busy1)
`ifdef WORD_BYTE_UNPACKER_LAST_EN
    , .out_last(last1)
`endif
  );

  word_byte_unpacker #(.SWAP(1'b0)) u_swap0 (
    .CLK(CLK), .ARST_N(ARST_N), .in_data(in_data), .in_valid(in_valid), .in_ready(ir0),
    .out_data(d0), .out_valid(ov0), .out_ready(out_ready), .busy(busy0)
`ifdef WORD_BYTE_UNPACKER_LAST_EN
    , .out_last(last0)
`endif
  );

  typedef struct {
    logic        iv;
    logic [15:0] id;
    logic        ordy;
    logic        ir;
    logic        ov;
    logic [7:0]  d1;
    logic [7:0]  d0;
    logic        busy;
    logic        last;
  } row_t;

  row_t rows [22];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs just after the falling edge and check the outputs 1ns later.
  task automatic apply(input row_t r, input string tag);
    in_valid  = r.iv;
    in_data   = r.id;
    out_ready = r.ordy;
    #1;
    chk({tag, ".in_ready1"}, {15'd0, ir1}, {15'd0, r.ir});
    chk({tag, ".in_ready0"}, {15'd0, ir0}, {15'd0, r.ir});
    chk({tag, ".out_valid1"}, {15'd0, ov1}, {15'd0, r.ov});
    chk({tag, ".out_valid0"}, {15'd0, ov0}, {15'd0, r.ov});
    chk({tag, ".busy1"}, {15'd0, busy1}, {15'd0, r.busy});
    chk({tag, ".busy0"}, {15'd0, busy0}, {15'd0, r.busy});
    chk({tag, ".out_data_swap1"}, {8'd0, d1}, {8'd0, r.d1});
    chk({tag, ".out_data_swap0"}, {8'd0, d0}, {8'd0, r.d0});
`ifdef WORD_BYTE_UNPACKER_LAST_EN
    chk({tag, ".out_last1"}, {15'd0, last1}, {15'd0, r.last});
    chk({tag, ".out_last0"}, {15'd0, last0}, {15'd0, r.last});
`endif
  endtask

  initial begin
    //           iv  in_data   ordy ir  ov  d(swap1) d(swap0) busy last
    rows[0]  = '{1'b1, 16'hA55A, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
    rows[1]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 8'hA5, 8'h5A, 1'b1, 1'b0};
    rows[2]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 8'h5A, 8'hA5, 1'b1, 1'b1};
    rows[3]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
    rows[4]  = '{1'b1, 16'h1234, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
    rows[5]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 8'h12, 8'h34, 1'b1, 1'b0};
    rows[6]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 8'h34, 8'h12, 1'b1, 1'b1};
    rows[7]  = '{1'b1, 16'h0102, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
    rows[8]  = '{1'b1, 16'h0304, 1'b1, 1'b0, 1'b1, 8'h01, 8'h02, 1'b1, 1'b0};
    rows[9]  = '{1'b1, 16'h0304, 1'b1, 1'b1, 1'b1, 8'h02, 8'h01, 1'b1, 1'b1};
    rows[10] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 8'h03, 8'h04, 1'b1, 1'b0};
    rows[11] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 8'h04, 8'h03, 1'b1, 1'b1};
    rows[12] = '{1'b1, 16'hBEEF, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
    rows[13] = '{1'b1, 16'hxxxx, 1'b0, 1'b0, 1'b1, 8'hBE, 8'hEF, 1'b1, 1'b0};
    rows[14] = '{1'b0, 16'hxxxx, 1'b0, 1'b0, 1'b1, 8'hBE, 8'hEF, 1'b1, 1'b0};
    rows[15] = '{1'b1, 16'hxxxx, 1'b0, 1'b0, 1'b1, 8'hBE, 8'hEF, 1'b1, 1'b0};
    rows[16] = '{1'b0, 16'hxxxx, 1'b0, 1'b0, 1'b1, 8'hBE, 8'hEF, 1'b1, 1'b0};
    rows[17] = '{1'b1, 16'hxxxx, 1'b0, 1'b0, 1'b1, 8'hBE, 8'hEF, 1'b1, 1'b0};
    rows[18] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 8'hBE, 8'hEF, 1'b1, 1'b0};
    rows[19] = '{1'b1, 16'hxxxx, 1'b0, 1'b0, 1'b1, 8'hEF, 8'hBE, 1'b1, 1'b1};
    rows[20] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 8'hEF, 8'hBE, 1'b1, 1'b1};
    rows[21] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};

    // Reset state, with garbage on in_data while held in reset.
    in_data = 16'hxxxx;
    repeat (2) @(negedge CLK);
    apply('{1'b1, 16'hxxxx, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0}, "reset");

    @(negedge CLK);
    ARST_N = 1'b1;
    in_valid = 1'b0;
    in_data = 16'h0000;

    for (int i = 0; i < 22; i++) begin
      @(negedge CLK);
      apply(rows[i], $sformatf("row%0d", i));
    end

    // Reset while the second byte of CAFE is pending.
    @(negedge CLK);
    apply('{1'b1, 16'hCAFE, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0}, "cafe_load");
    @(negedge CLK);
    apply('{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 8'hCA, 8'hFE, 1'b1, 1'b0}, "cafe_first");
    @(negedge CLK);
    apply('{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 8'hFE, 8'hCA, 1'b1, 1'b1}, "cafe_second");
    #2;
    ARST_N = 1'b0;
    apply('{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0}, "cafe_reset");

    // Word accepted on the first edge after release, no stale CAFE byte.
    @(negedge CLK);
    ARST_N = 1'b1;
    apply('{1'b1, 16'h0F0F, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0}, "post_load");
    @(negedge CLK);
    apply('{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 8'h0F, 8'h0F, 1'b1, 1'b0}, "post_first");
    @(negedge CLK);
    apply('{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 8'h0F, 8'h0F, 1'b1, 1'b1}, "post_second");
    @(negedge CLK);
    apply('{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0}, "post_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/word_byte_unpacker.md
WORD_BYTE_UNPACKER -- requirements
Module: word_byte_unpacker

Interface
REQ-001 Parameter SWAP, default 1: byte emission order; 0 = bits[7:0] first, 1 = bits[15:8] first (byte-swapped view).
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 ARST_N  input  1  asynchronous active-low reset; asserts immediately, deasserts synchronously to CLK.
REQ-004 in_data  input  16  word to unpack.
REQ-005 in_valid  input  1  in_data valid.
REQ-006 in_ready  output  1  block can accept a word this cycle.
REQ-007 out_data  output  8  current byte.
REQ-008 out_valid  output  1  out_data valid.
REQ-009 out_ready  input  1  downstream accepts byte this cycle.
REQ-010 busy  output  1  high while any byte of a held word is unsent.

Function
REQ-011 Word transfer shall occur on a cycle with in_valid && in_ready; byte transfer on out_valid && out_ready.
REQ-012 FSM states: EMPTY, FIRST (first byte pending), SECOND (second byte pending); encoding in package.
REQ-013 EMPTY: in_ready=1, out_valid=0; word transfer captures in_data into 16-bit hold register, next state FIRST.
REQ-014 FIRST: out_valid=1, out_data = first byte per SWAP, in_ready=0; byte transfer -> SECOND; otherwise hold.
REQ-015 SECOND: out_valid=1, out_data = other byte; in_ready = out_ready (pass-through for back-to-back words).
REQ-016 SECOND with byte transfer and simultaneous word transfer: capture new word, next state FIRST, no idle cycle.
REQ-017 SECOND with byte transfer and no word transfer: next state EMPTY.
REQ-018 Latency: first byte valid one cycle after word transfer; sustained throughput one byte per cycle when out_ready held high.
REQ-019 out_data and out_valid shall be driven from registered state only; out_data stable while out_valid && !out_ready.
REQ-020 in_ready shall not depend combinationally on in_valid; out_valid shall not depend on out_ready.
REQ-021 busy = (state != EMPTY).
REQ-022 in_data is ignored when no word transfer occurs; X on in_data without in_valid shall not propagate.

Reset
REQ-023 On ARST_N low: state EMPTY, hold register 16'h0000, out_valid=0, out_data=8'h00, in_ready=1, busy=0, out_last=0 if present.
REQ-024 Reset mid-word shall discard the held word; no byte of it is emitted after reset release.
REQ-025 First word transfer possible on the first rising edge after ARST_N deasserts.

Configuration
REQ-026 Macro WORD_BYTE_UNPACKER_LAST_EN: when defined, add output out_last (1 bit) = 1 exactly when state is SECOND, marking the final byte of a word.
REQ-027 Without WORD_BYTE_UNPACKER_LAST_EN, out_last port and its logic shall not exist; all other behaviour identical.

Structure
REQ-028 Shared package word_byte_pkg: WORD_W=16, BYTE_W=8, state enum type, byte-select helper function (word, swap, index) -> byte.
REQ-029 One sub-module word_byte_sel: combinational 16-to-8 selector keyed by SWAP and state; no other hierarchy.

Verification
REQ-030 SWAP=1, word 16'hA55A, out_ready=1 -> bytes 8'hA5 then 8'h5A on consecutive cycles, busy high two cycles.
REQ-031 SWAP=0, word 16'h1234 -> bytes 8'h34 then 8'h12; out_last (if enabled) high only with 8'h12.
REQ-032 Back-to-back words 16'h0102, 16'h0304, in_valid and out_ready held high, SWAP=1 -> 01,02,03,04 with no gap; in_ready high every second cycle.
REQ-033 out_ready low for 5 cycles during FIRST with word 16'hBEEF -> out_data stays 8'hBE, in_ready=0, then BE, EF emitted in order.
REQ-034 ARST_N pulsed low while in SECOND of 16'hCAFE -> out_valid drops immediately, state EMPTY; next word 16'h0F0F emits 0F,0F with no stale byte.
REQ-035 in_valid toggling with in_data=X while in_ready=0 -> no capture, no X on out_data.
